conv_load_ctrl: RTL and testbench

Sequencer for one convolution job. Takes a host byte stream over a valid/ready handshake, writes the weight RAM (3x3x3x2 = 54 entries) and then the data RAM (8x8x1 = 64 entries) at auto-incrementing addresses, and then fires the convolution engine. It ends the job when the engine reports done. It sits between the host load port and the weight/data RAMs plus conv core, and owns both RAM write ports.

---
 rtl/conv_load_ctrl.sv | 123 ++++++++++++
 tb/tb_conv_load_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_load_ctrl.sv
// Convolution job sequencer: streams host words into the weight and data RAMs,
// then starts the conv engine and waits for it to finish.
module conv_load_ctrl #(
    parameter int DW           = 8,
    parameter int DATA_DEPTH   = 64,
    parameter int WEIGHT_DEPTH = 54
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    input  logic                            reload_w,
    input  logic                            in_valid,
    input  logic [DW-1:0]                   in_data,
    output logic                            in_ready,
    output logic                            weight_ram_en,
    output logic [$clog2(WEIGHT_DEPTH)-1:0] weight_ram_waddr,
    output logic                            data_ram_en,
    output logic [$clog2(DATA_DEPTH)-1:0]   data_ram_waddr,
    output logic [DW-1:0]                   ram_wdata,
    output logic                            conv_start,
    input  logic                            conv_done,
    output logic                            busy,
    output logic                            job_done,
    output logic                            weights_loaded
);

    localparam int WAW = $clog2(WEIGHT_DEPTH);
    localparam int DAW = $clog2(DATA_DEPTH);
    localparam logic [WAW-1:0] W_LAST = WAW'(WEIGHT_DEPTH - 1);
    localparam logic [DAW-1:0] D_LAST = DAW'(DATA_DEPTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_W,
        LOAD_D,
        FLUSH,
        RUN
    } state_t;

    state_t         state;
    logic [WAW-1:0] wcnt;
    logic [DAW-1:0] dcnt;

    assign in_ready = (state == LOAD_W) || (state == LOAD_D);
    assign busy     = (state != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            wcnt             <= '0;
            dcnt             <= '0;
            weight_ram_en    <= 1'b0;
            weight_ram_waddr <= '0;
            data_ram_en      <= 1'b0;
            data_ram_waddr   <= '0;
            ram_wdata        <= '0;
            conv_start       <= 1'b0;
            job_done         <= 1'b0;
            weights_loaded   <= 1'b0;
        end else begin
            // Strobes are single-cycle; only a beat or a transition re-raises them.
            weight_ram_en <= 1'b0;
            data_ram_en   <= 1'b0;
            conv_start    <= 1'b0;
            job_done      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (reload_w || !weights_loaded) begin
                            state          <= LOAD_W;
                            wcnt           <= '0;
                            weights_loaded <= 1'b0;
                        end else begin
                            state <= LOAD_D;
                            dcnt  <= '0;
                        end
                    end
                end
                LOAD_W: begin
                    if (in_valid) begin
                        weight_ram_en    <= 1'b1;
                        weight_ram_waddr <= wcnt;
                        ram_wdata        <= in_data;
                        if (wcnt == W_LAST) begin
                            wcnt           <= '0;
                            dcnt           <= '0;
                            weights_loaded <= 1'b1;
                            state          <= LOAD_D;
                        end else begin
                            wcnt <= wcnt + WAW'(1);
                        end
                    end
                end
                LOAD_D: begin
                    if (in_valid) begin
                        data_ram_en    <= 1'b1;
                        data_ram_waddr <= dcnt;
                        ram_wdata      <= in_data;
                        if (dcnt == D_LAST) begin
                            dcnt  <= '0;
                            state <= FLUSH;
                        end else begin
                            dcnt <= dcnt + DAW'(1);
                        end
                    end
                end
                // One idle cycle lets the last data write land before the engine reads.
                FLUSH: begin
                    state      <= RUN;
                    conv_start <= 1'b1;
                end
                RUN: begin
                    if (conv_done) begin
                        job_done <= 1'b1;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_load_ctrl.sv
// Directed bench for conv_load_ctrl: full jobs, weight reuse, stalls,
// ignored controls and mid-job reset.
module tb_conv_load_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       reload_w = 1'b0;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = '0;
    logic       in_ready;
    logic       weight_ram_en;
    logic [5:0] weight_ram_waddr;
    logic       data_ram_en;
    logic [5:0] data_ram_waddr;
    logic [7:0] ram_wdata;
    logic       conv_start;
    logic       conv_done = 1'b0;
    logic       busy;
    logic       job_done;
    logic       weights_loaded;

    int checks = 0;
    int failures = 0;

    logic [5:0] waq[$];
    logic [7:0] wdq[$];
    logic [5:0] daq[$];
    logic [7:0] ddq[$];

    conv_load_ctrl #(.DW(8), .DATA_DEPTH(64), .WEIGHT_DEPTH(54)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .start(start),
        .reload_w(reload_w),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .weight_ram_en(weight_ram_en),
        .weight_ram_waddr(weight_ram_waddr),
        .data_ram_en(data_ram_en),
        .data_ram_waddr(data_ram_waddr),
        .ram_wdata(ram_wdata),
        .conv_start(conv_start),
        .conv_done(conv_done),
        .busy(busy),
        .job_done(job_done),
        .weights_loaded(weights_loaded)
    );

    always #5 clk = ~clk;

    // Write logger and invariant monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n) begin
            if (weight_ram_en) begin
                waq.push_back(weight_ram_waddr);
                wdq.push_back(ram_wdata);
            end
            if (data_ram_en) begin
                daq.push_back(data_ram_waddr);
                ddq.push_back(ram_wdata);
            end
            checks++;
            if (weight_ram_en && data_ram_en) begin
                failures++;
                $display("FAIL both_en: weight_ram_en=%b data_ram_en=%b required not both 1",
                         weight_ram_en, data_ram_en);
            end
            checks++;
            if (in_ready && (conv_start || job_done || !busy)) begin
                failures++;
                $display("FAIL ready_state: in_ready=1 with conv_start=%b job_done=%b busy=%b",
                         conv_start, job_done, busy);
            end
        end
    end

    task automatic clear_q();
        waq.delete();
        wdq.delete();
        daq.delete();
        ddq.delete();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({in_ready, weight_ram_en, data_ram_en, conv_start, busy, job_done,
             weights_loaded} !== 7'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b required 0000000",
                     {in_ready, weight_ram_en, data_ram_en, conv_start, busy,
                      job_done, weights_loaded});
        end
        checks++;
        if ({weight_ram_waddr, data_ram_waddr, ram_wdata} !== 20'h0) begin
            failures++;
            $display("FAIL reset_buses: got %h required 0",
                     {weight_ram_waddr, data_ram_waddr, ram_wdata});
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_full_job(input logic rw);
        clear_q();
        start = 1'b1;
        reload_w = rw;
        @(posedge clk);
        #1;
        start = 1'b0;
        reload_w = 1'b0;
        checks++;
        if ({in_ready, busy, weights_loaded} !== 3'b110) begin
            failures++;
            $display("FAIL job_enter_w: ready/busy/wl=%b required 110",
                     {in_ready, busy, weights_loaded});
        end
        in_valid = 1'b1;
        for (int i = 0; i < 118; i++) begin
            in_data = 8'(i);
            @(posedge clk);
            #1;
            if (i == 52) begin
                checks++;
                if (weights_loaded !== 1'b0) begin
                    failures++;
                    $display("FAIL wl_early: got %b required 0", weights_loaded);
                end
            end
            if (i == 53) begin
                checks++;
                if ({weights_loaded, in_ready, weight_ram_en} !== 3'b111 ||
                    weight_ram_waddr !== 6'd53) begin
                    failures++;
                    $display("FAIL last_w_beat: wl/rdy/en=%b addr=%0d required 111 addr=53",
                             {weights_loaded, in_ready, weight_ram_en}, weight_ram_waddr);
                end
            end
            if (i == 54) begin
                checks++;
                if (data_ram_en !== 1'b1 || data_ram_waddr !== 6'd0 ||
                    ram_wdata !== 8'd54) begin
                    failures++;
                    $display("FAIL first_d_beat: en=%b addr=%0d data=%0d required 1 0 54",
                             data_ram_en, data_ram_waddr, ram_wdata);
                end
            end
        end
        in_valid = 1'b0;
        checks++;
        if ({in_ready, conv_start, busy} !== 3'b001) begin
            failures++;
            $display("FAIL flush: rdy/cs/busy=%b required 001", {in_ready, conv_start, busy});
        end
        @(posedge clk);
        #1;
        checks++;
        if (conv_start !== 1'b1) begin
            failures++;
            $display("FAIL conv_start_hi: got %b required 1", conv_start);
        end
        @(posedge clk);
        #1;
        checks++;
        if (conv_start !== 1'b0) begin
            failures++;
            $display("FAIL conv_start_lo: got %b required 0", conv_start);
        end
        checks++;
        if (waq.size() != 54 || daq.size() != 64) begin
            failures++;
            $display("FAIL write_counts: weights=%0d data=%0d required 54 64",
                     waq.size(), daq.size());
        end else begin
            for (int i = 0; i < 54; i++) begin
                checks++;
                if (waq[i] !== 6'(i) || wdq[i] !== 8'(i)) begin
                    failures++;
                    $display("FAIL w_write[%0d]: addr=%0d data=%0d required %0d %0d",
                             i, waq[i], wdq[i], i, i);
                end
            end
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (daq[i] !== 6'(i) || ddq[i] !== 8'(54 + i)) begin
                    failures++;
                    $display("FAIL d_write[%0d]: addr=%0d data=%0d required %0d %0d",
                             i, daq[i], ddq[i], i, 54 + i);
                end
            end
        end
        repeat (3) @(posedge clk);
        #1;
        conv_done = 1'b1;
        @(posedge clk);
        #1;
        conv_done = 1'b0;
        checks++;
        if ({job_done, busy} !== 2'b10) begin
            failures++;
            $display("FAIL job_end: done/busy=%b required 10", {job_done, busy});
        end
        @(posedge clk);
        #1;
        checks++;
        if (job_done !== 1'b0) begin
            failures++;
            $display("FAIL job_done_pulse: got %b required 0", job_done);
        end
    endtask

    task automatic test_reuse_stall();
        int beat;
        clear_q();
        start = 1'b1;
        reload_w = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        checks++;
        if ({in_ready, weights_loaded} !== 2'b11) begin
            failures++;
            $display("FAIL reuse_enter: rdy/wl=%b required 11", {in_ready, weights_loaded});
        end
        beat = 0;
        for (int c = 0; c < 128; c++) begin
            in_valid = (c % 2 == 0);
            in_data = 8'(100 + beat);
            start = (c == 10);
            @(posedge clk);
            #1;
            start = 1'b0;
            checks++;
            if (data_ram_en !== in_valid ||
                (in_valid && data_ram_waddr !== 6'(beat))) begin
                failures++;
                $display("FAIL stall_c%0d: en=%b addr=%0d required en=%b addr=%0d",
                         c, data_ram_en, data_ram_waddr, in_valid, beat);
            end
            if (in_valid) beat++;
        end
        in_valid = 1'b0;
        checks++;
        if ({conv_start, in_ready} !== 2'b10) begin
            failures++;
            $display("FAIL stall_run: cs/rdy=%b required 10", {conv_start, in_ready});
        end
        checks++;
        if (waq.size() != 0 || daq.size() != 64) begin
            failures++;
            $display("FAIL reuse_counts: weights=%0d data=%0d required 0 64",
                     waq.size(), daq.size());
        end else begin
            for (int i = 0; i < 64; i++) begin
                checks++;
                if (daq[i] !== 6'(i) || ddq[i] !== 8'(100 + i)) begin
                    failures++;
                    $display("FAIL reuse_write[%0d]: addr=%0d data=%0d required %0d %0d",
                             i, daq[i], ddq[i], i, 100 + i);
                end
            end
        end
        conv_done = 1'b1;
        @(posedge clk);
        #1;
        conv_done = 1'b0;
        checks++;
        if ({job_done, busy} !== 2'b10) begin
            failures++;
            $display("FAIL early_done: done/busy=%b required 10", {job_done, busy});
        end
    endtask

    task automatic test_idle_ignore();
        @(posedge clk);
        #1;
        conv_done = 1'b1;
        @(posedge clk);
        #1;
        conv_done = 1'b0;
        checks++;
        if ({busy, job_done, in_ready, conv_start} !== 4'b0) begin
            failures++;
            $display("FAIL idle_done: busy/done/rdy/cs=%b required 0000",
                     {busy, job_done, in_ready, conv_start});
        end
    endtask

    task automatic test_reset_midjob();
        start = 1'b1;
        reload_w = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        reload_w = 1'b0;
        checks++;
        if ({in_ready, weights_loaded} !== 2'b10) begin
            failures++;
            $display("FAIL reload_clear: rdy/wl=%b required 10", {in_ready, weights_loaded});
        end
        in_valid = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_data = 8'(200 + i);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, weight_ram_en, data_ram_en, conv_start, busy, job_done,
             weights_loaded} !== 7'b0 ||
            {weight_ram_waddr, data_ram_waddr, ram_wdata} !== 20'h0) begin
            failures++;
            $display("FAIL midjob_reset: flags=%b buses=%h required 0",
                     {in_ready, weight_ram_en, data_ram_en, conv_start, busy,
                      job_done, weights_loaded},
                     {weight_ram_waddr, data_ram_waddr, ram_wdata});
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_full_job(1'b0);
    endtask

    initial begin
        test_reset();
        test_full_job(1'b0);
        test_reuse_stall();
        test_idle_ignore();
        test_reset_midjob();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
